// File: rtl/io_bridge.sv
// io_bridge: CPU I/O bridge with UART tx FIFO, rx read port, cycle counter; define IO_BRIDGE_CYCLE_SNAPSHOT_EN for coherent counter reads
module io_bridge #(
  parameter int TXQ_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  io_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        halt,
  output logic        tx_overflow
);
  localparam logic [TXQ_AW:0] DEPTH = {1'b1, {TXQ_AW{1'b0}}};
  localparam logic [TXQ_AW:0] HI_MARK = DEPTH - 1'b1;
  logic [7:0]        r_mem [2**TXQ_AW];
  logic [TXQ_AW-1:0] r_wp, r_rp;
  logic [TXQ_AW:0]   r_count;
  logic [31:0]       r_cyc;
  logic              w_io, w_wr, w_rd, w_req, w_pop, w_full, w_push, w_drop, w_unused;
  logic [15:0]       w_off;
  logic [31:0]       w_src;
  logic [7:0]        w_rdata, w_pdata;
  assign w_unused = ^mem_a[31:18];
  assign w_io = en && mem_a[17:16] == 2'b11;
  assign w_off = mem_a[15:0];
  assign w_wr = w_io && mem_wr;
  assign w_rd = w_io && !mem_wr;
  assign w_req = w_wr && !halt && ((w_off == 16'h0 && mem_dout != 8'h00) || w_off == 16'h4);
  assign w_pdata = (w_off == 16'h4) ? 8'h00 : mem_dout;
  assign tx_valid = r_count != '0;
  assign tx_data = r_mem[r_rp];
  assign w_pop = tx_valid && tx_ready;
  assign w_full = r_count == DEPTH;
  // a pop on the same edge frees the slot, so a full FIFO can still accept
  assign w_push = w_req && (!w_full || w_pop);
  assign w_drop = w_req && w_full && !w_pop;
  assign io_buffer_full = r_count >= HI_MARK;
`ifdef IO_BRIDGE_CYCLE_SNAPSHOT_EN
  logic [31:0] r_snap;
  assign w_src = (w_off == 16'h4) ? r_cyc : r_snap;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_snap <= '0;
    else if (w_rd && w_off == 16'h4) r_snap <= r_cyc;
`else
  assign w_src = r_cyc;
`endif
  assign w_rdata = (w_off == 16'h0) ? (rx_valid ? rx_data : 8'h00) :
                   (w_off[15:2] == 14'h1) ? w_src[8*w_off[1:0] +: 8] : 8'h00;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= w_pdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wp        <= '0;
      r_rp        <= '0;
      r_count     <= '0;
      r_cyc       <= '0;
      io_din      <= '0;
      rx_pop      <= 1'b0;
      halt        <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + {{TXQ_AW{1'b0}}, w_push} - {{TXQ_AW{1'b0}}, w_pop};
      if (en) r_cyc <= r_cyc + 1'b1;
      if (w_rd) io_din <= w_rdata;
      rx_pop <= w_rd && w_off == 16'h0 && rx_valid;
      if (w_wr && w_off == 16'h4) halt <= 1'b1;
      if (w_drop) tx_overflow <= 1'b1;
    end
endmodule

// File: tb/tb_io_bridge.sv
// tb_io_bridge: directed self-checking bench for io_bridge
module tb_io_bridge;
  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, mem_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] mem_a = '0;
  logic [7:0]  mem_dout = '0, rx_data = '0;
  logic [7:0]  io_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_pop, halt, tx_overflow;
  logic [31:0] m_cnt;
  logic [7:0]  exp_b;
  int n_tot = 0, n_bad = 0;
`ifdef IO_BRIDGE_CYCLE_SNAPSHOT_EN
  localparam logic [7:0] B1 = 8'h00;
`else
  localparam logic [7:0] B1 = 8'h01;
`endif
  io_bridge #(.TXQ_AW(3)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .io_din(io_din), .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
    .halt(halt), .tx_overflow(tx_overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk or negedge rst)
    if (!rst) m_cnt <= '0;
    else if (en) m_cnt <= m_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
    mem_a = a;
    mem_wr = wr;
    mem_dout = d;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_io_din", io_din, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_halt", halt, 0);
    chk("rst_ovf", tx_overflow, 0);
    chk("rst_rx_pop", rx_pop, 0);
    chk("rst_full", io_buffer_full, 0);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    repeat (255) cyc();
    bus(32'h30004, 0, 0); cyc(); chk("cnt_b0", io_din, 8'hFF);
    bus(32'h30005, 0, 0); cyc(); chk("cnt_b1", io_din, B1);
    bus(32'h30006, 0, 0); cyc(); chk("cnt_b2", io_din, 8'h00);
    bus(32'h30007, 0, 0); cyc(); chk("cnt_b3", io_din, 8'h00);
    tx_ready = 1'b1;
    bus(32'h30000, 1, 8'h41); cyc();
    chk("tx41_valid", tx_valid, 1);
    chk("tx41_data", tx_data, 8'h41);
    bus(32'h30000, 1, 8'h42); cyc();
    chk("pushpop_valid", tx_valid, 1);
    chk("pushpop_data", tx_data, 8'h42);
    bus(0, 0, 0); cyc();
    chk("tx_empty", tx_valid, 0);
    tx_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus(32'h30000, 1, 8'(i)); cyc();
      if (i == 6) chk("full_at6", io_buffer_full, 0);
      if (i == 7) chk("full_at7", io_buffer_full, 1);
    end
    chk("ovf_before", tx_overflow, 0);
    bus(32'h30000, 1, 8'h09); cyc();
    chk("ovf_after", tx_overflow, 1);
    bus(0, 0, 0);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", tx_valid, 1);
      chk("drain_data", tx_data, i);
      cyc();
    end
    chk("drain_empty", tx_valid, 0);
    chk("drain_notfull", io_buffer_full, 0);
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    bus(32'h30000, 0, 0); cyc();
    chk("rx_data", io_din, 8'h5A);
    chk("rx_pop_pulse", rx_pop, 1);
    bus(0, 0, 0); cyc();
    chk("rx_pop_end", rx_pop, 0);
    chk("rx_hold", io_din, 8'h5A);
    rx_valid = 1'b0;
    rx_data = 8'h77;
    bus(32'h30000, 0, 0); cyc();
    chk("rx_empty_data", io_din, 0);
    chk("rx_empty_pop", rx_pop, 0);
    tx_ready = 1'b0;
    bus(32'h30000, 1, 8'h00); cyc();
    chk("zero_nopush", tx_valid, 0);
    exp_b = m_cnt[7:0];
    bus(32'h30004, 0, 0); cyc();
    chk("cnt_pre", io_din, exp_b);
    en = 1'b0;
    bus(32'h30000, 1, 8'h33);
    repeat (4) cyc();
    chk("en0_nopush", tx_valid, 0);
    bus(32'h30010, 0, 0); cyc();
    chk("en0_hold", io_din, exp_b);
    en = 1'b1;
    exp_b = m_cnt[7:0];
    bus(32'h30004, 0, 0); cyc();
    chk("cnt_frozen", io_din, exp_b);
    bus(32'h30010, 0, 0); cyc();
    chk("other_rd", io_din, 0);
    bus(32'h30000, 1, 8'h11); cyc();
    bus(32'h30000, 1, 8'h22); cyc();
    chk("pre_rst_valid", tx_valid, 1);
    bus(0, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", tx_valid, 0);
    chk("arst_ovf", tx_overflow, 0);
    @(negedge clk);
    rst = 1'b1;
    bus(32'h30000, 1, 8'h66); cyc();
    chk("post_rst_data", tx_data, 8'h66);
    chk("post_rst_full", io_buffer_full, 0);
    bus(0, 0, 0);
    tx_ready = 1'b1;
    cyc();
    chk("post_rst_empty", tx_valid, 0);
    tx_ready = 1'b0;
    bus(32'h30004, 1, 8'hAA); cyc();
    chk("halt_set", halt, 1);
    chk("halt_valid", tx_valid, 1);
    chk("halt_byte", tx_data, 8'h00);
    bus(32'h30000, 1, 8'h42); cyc();
    bus(0, 0, 0);
    tx_ready = 1'b1;
    cyc();
    chk("halt_nopush", tx_valid, 0);
    chk("halt_sticky", halt, 1);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
